// File: rtl/mram_read_pts.sv
// MRAM read-capture and parallel-to-serial stage feeding the SPI slave MISO path.
// Optional macro PTS_BYTE_MSB_FIRST_EN: low byte first, MSB-first within each byte.
module mram_read_pts #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned IDX_W         = 4,
    parameter int unsigned ACCESS_CYCLES = 4
) (
    input  logic              FPGA_clk,
    input  logic              FPGA_rst_n,
    input  logic              chip_en_n,
    input  logic              read_en_n,
    input  logic              PTS_en,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] mram_data_in,
    output logic              PTS_ser_data_out,
    output logic [DATA_W-1:0] hold_data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rd_strb_d;
    logic               rd_strb_c;
    logic               strb_rise_c;
    logic [IDX_W-1:0]   sel_c;

    assign rd_strb_c   = ~chip_en_n & ~read_en_n;
    assign strb_rise_c = rd_strb_c & ~rd_strb_d;

    // Bit ordering of the serial stream
`ifdef PTS_BYTE_MSB_FIRST_EN
    assign sel_c = {index[IDX_W-1], ~index[IDX_W-2:0]};
`else
    assign sel_c = index;
`endif

    // Strobe edge detect, access-latency FSM, capture and serial bit select
    always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
        if (!FPGA_rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            rd_strb_d        <= 1'b0;
            hold_data        <= '0;
            data_valid       <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            PTS_ser_data_out <= 1'b0;
        end else begin
            rd_strb_d        <= rd_strb_c;
            PTS_ser_data_out <= data_valid ? hold_data[sel_c] : 1'b0;

            // Disable wins over any strobe in the same cycle; hold_data is kept
            if (!PTS_en) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                busy       <= 1'b0;
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (strb_rise_c) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        // A new strobe aborts the pending access and restarts latency
                        if (strb_rise_c) begin
                            cnt     <= '0;
                            overrun <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            hold_data  <= mram_data_in;
                            data_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_HOLD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (strb_rise_c) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mram_read_pts.sv
// Randomized and directed bench for mram_read_pts against a deadline-based reference model.
module tb_mram_read_pts;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned AC     = 4;

    logic              FPGA_clk = 1'b0;
    logic              FPGA_rst_n;
    logic              chip_en_n;
    logic              read_en_n;
    logic              PTS_en;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] mram_data_in;
    logic              PTS_ser_data_out;
    logic [DATA_W-1:0] hold_data;
    logic              data_valid;
    logic              busy;
    logic              overrun;

    mram_read_pts #(
        .DATA_W(DATA_W),
        .IDX_W(IDX_W),
        .ACCESS_CYCLES(AC)
    ) dut (
        .FPGA_clk(FPGA_clk),
        .FPGA_rst_n(FPGA_rst_n),
        .chip_en_n(chip_en_n),
        .read_en_n(read_en_n),
        .PTS_en(PTS_en),
        .index(index),
        .mram_data_in(mram_data_in),
        .PTS_ser_data_out(PTS_ser_data_out),
        .hold_data(hold_data),
        .data_valid(data_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 FPGA_clk = ~FPGA_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a read completes at a known absolute cycle (deadline)
    int                cyc       = 0;
    int                pending   = -1;
    bit                m_prev    = 1'b0;
    bit                m_valid   = 1'b0;
    bit                m_ovr     = 1'b0;
    bit                m_ser     = 1'b0;
    logic [DATA_W-1:0] m_hold    = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bit_pos(input logic [IDX_W-1:0] idx);
`ifdef PTS_BYTE_MSB_FIRST_EN
        return (int'(idx) / 8) * 8 + 7 - (int'(idx) % 8);
`else
        return int'(idx);
`endif
    endfunction

    // Advance model and DUT one clock, then compare every output
    task automatic step();
        bit strb;
        bit rise;
        bit ser_next;
        strb     = !chip_en_n && !read_en_n;
        rise     = strb && !m_prev;
        ser_next = m_valid ? m_hold[bit_pos(index)] : 1'b0;
        if (!FPGA_rst_n) begin
            m_prev  = 1'b0;
            pending = -1;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ser   = 1'b0;
            m_hold  = '0;
        end else begin
            m_prev = strb;
            m_ser  = ser_next;
            if (!PTS_en) begin
                pending = -1;
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end else if (rise) begin
                if (pending >= 0) m_ovr = 1'b1;
                pending = cyc + int'(AC);
            end else if (pending == cyc) begin
                m_hold  = mram_data_in;
                m_valid = 1'b1;
                pending = -1;
            end
        end
        @(posedge FPGA_clk);
        #1;
        cyc++;
        check_eq("ser_out", 32'(PTS_ser_data_out), 32'(m_ser));
        check_eq("hold_data", 32'(hold_data), 32'(m_hold));
        check_eq("data_valid", 32'(data_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), (pending >= 0) ? 32'd1 : 32'd0);
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic strobe_pulse(input logic [DATA_W-1:0] d);
        mram_data_in = d;
        chip_en_n    = 1'b0;
        read_en_n    = 1'b0;
        step();
        chip_en_n    = 1'b1;
        read_en_n    = 1'b1;
    endtask

    logic [15:0] ser_seq;

    initial begin
        FPGA_rst_n   = 1'b0;
        chip_en_n    = 1'b1;
        read_en_n    = 1'b1;
        PTS_en       = 1'b0;
        index        = '0;
        mram_data_in = '0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            chip_en_n    = 1'($urandom);
            read_en_n    = 1'($urandom);
            PTS_en       = 1'($urandom);
            index        = IDX_W'($urandom);
            mram_data_in = DATA_W'($urandom);
            step();
        end
        check_eq("rst_hold", 32'(hold_data), 32'd0);
        chip_en_n  = 1'b1;
        read_en_n  = 1'b1;
        PTS_en     = 1'b1;
        FPGA_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("post_rst_valid", 32'(data_valid), 32'd0);

        // Single read, busy cycles 1..AC, capture visible in AC+1
        strobe_pulse(16'hA5C3);
        for (int i = 1; i <= int'(AC); i++) begin
            check_eq("single_busy", 32'(busy), 32'd1);
            step();
        end
        check_eq("single_hold", 32'(hold_data), 32'hA5C3);
        check_eq("single_valid", 32'(data_valid), 32'd1);
        check_eq("single_busy_end", 32'(busy), 32'd0);

        // Serial order for 16'h00A5
        step();
        strobe_pulse(16'h00A5);
        for (int i = 0; i < int'(AC) + 1; i++) step();
        ser_seq = 16'h00A5;
        for (int i = 0; i < 16; i++) begin
            index = IDX_W'(i);
            step();
            check_eq("ser_order", 32'(PTS_ser_data_out), 32'(ser_seq[i]));
        end

        // Burst: two strobes 20 cycles apart
        strobe_pulse(16'h1234);
        for (int i = 0; i < 19; i++) begin
            step();
            if (i == int'(AC)) check_eq("burst_first", 32'(hold_data), 32'h1234);
        end
        strobe_pulse(16'hBEEF);
        for (int i = 0; i < int'(AC) + 1; i++) begin
            check_eq("burst_valid", 32'(data_valid), 32'd1);
            step();
        end
        check_eq("burst_second", 32'(hold_data), 32'hBEEF);
        check_eq("burst_ovr", 32'(overrun), 32'd0);

        // Overrun: second strobe at cycle 2, only word at cycle 2+AC captured
        step();
        strobe_pulse(16'h1111);
        mram_data_in = 16'h1111;
        step();
        strobe_pulse(16'h2222);
        for (int j = 3; j <= 7; j++) begin
            mram_data_in = 16'hC000 | 16'(j);
            step();
        end
        check_eq("ovr_hold", 32'(hold_data), 32'hC000 | (32'(2) + 32'(AC)));
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        PTS_en = 1'b0;
        step();
        check_eq("dis_ovr", 32'(overrun), 32'd0);
        check_eq("dis_valid", 32'(data_valid), 32'd0);
        PTS_en = 1'b1;
        step();

        // Reset pulsed mid-WAIT
        strobe_pulse(16'h7777);
        step();
        FPGA_rst_n = 1'b0;
        #1;
        check_eq("rst_wait_busy", 32'(busy), 32'd0);
        check_eq("rst_wait_hold", 32'(hold_data), 32'd0);
        step();
        FPGA_rst_n = 1'b1;
        for (int i = 0; i < int'(AC) + 2; i++) step();
        check_eq("rst_wait_nocap", 32'(hold_data), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            FPGA_rst_n   = ($urandom_range(299) != 0);
            PTS_en       = ($urandom_range(39) != 0);
            chip_en_n    = ($urandom_range(9) < 2) ? 1'b0 : 1'b1;
            read_en_n    = ($urandom_range(9) < 6) ? 1'b0 : 1'b1;
            index        = IDX_W'($urandom);
            mram_data_in = DATA_W'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mram_read_pts.md
# mram_read_pts

MRAM read-capture and parallel-to-serial stage sitting between the MRAM data bus and the SPI slave's MISO path. It detects each MRAM read strobe issued by the SPI slave and waits a fixed access latency. It then latches the 16-bit read word and presents the bit selected by the slave's `index` on `PTS_ser_data_out`, which drives the slave's `PTS_ser_data_in`. Burst reads are handled per word: every read strobe captures a fresh word.

## Interface
- `DATA_W`, 16, width of MRAM data word; fixed at 16 for this design.
- `IDX_W`, 4, width of bit-select index (log2 DATA_W).
- `ACCESS_CYCLES`, 4, FPGA_clk cycles from strobe detection to data sampling; legal range 1..15.

Ports:
- `FPGA_clk` in 1: system clock, all logic on rising edge.
- `FPGA_rst_n` in 1: asynchronous, active-low reset.
- `chip_en_n` in 1: MRAM chip enable from SPI slave (active low).
- `read_en_n` in 1: MRAM read enable from SPI slave (active low).
- `PTS_en` in 1: serialiser enable from SPI slave; low forces idle.
- `index` in IDX_W: bit select from SPI slave (0 = first bit shifted out).
- `mram_data_in` in DATA_W: MRAM read data bus.
- `PTS_ser_data_out` out 1: selected serial bit, registered.
- `hold_data` out DATA_W: last captured word.
- `data_valid` out 1: hold_data holds a word captured since PTS_en rose.
- `busy` out 1: high while waiting out the access latency.
- `overrun` out 1: sticky; a new strobe arrived while busy.

## Operation
- All inputs are synchronous to FPGA_clk; there is no synchroniser.
- The strobe is `rd_strb = ~chip_en_n & ~read_en_n`. It is registered into `rd_strb_d`. `strb_rise = rd_strb & ~rd_strb_d`.
- The state machine has three states:
  - IDLE:
    - On `strb_rise & PTS_en`, go to WAIT with `cnt <= 0`.
  - WAIT (`busy = 1`):
    - `cnt` increments each cycle.
    - When `cnt == ACCESS_CYCLES-1`: `hold_data <= mram_data_in`, `data_valid <= 1`, go to HOLD.
  - HOLD:
    - On `strb_rise`, go to WAIT with `cnt <= 0`.
    - `data_valid` stays 1 and the old word stays in `hold_data` until the new capture.
- `strb_rise` while in WAIT: restart `cnt <= 0` and set `overrun <= 1`. No capture happens for the aborted strobe.
- `PTS_en` sampled low in any state: go to IDLE, `data_valid <= 0`, `overrun <= 0`. `hold_data` is retained.
  - This takes priority over `strb_rise` in the same cycle.
- Bit select `sel` (IDX_W bits), mapping set by Configuration:
  - `PTS_ser_data_out <= data_valid ? hold_data[sel] : 0`.
- `cnt` is 4 bits wide and never wraps, because the terminal count is at most 14.

## Timing
- Reset values: `PTS_ser_data_out = 0`, `hold_data = 0`, `data_valid = 0`, `busy = 0`, `overrun = 0`. State is IDLE, `cnt = 0`, `rd_strb_d = 0`.
- Let cycle 0 be the cycle in which `strb_rise` is high.
  - WAIT is entered in cycle 1.
  - `mram_data_in` is sampled at the clock edge ending cycle `ACCESS_CYCLES`.
  - `hold_data` and `data_valid` update in cycle `ACCESS_CYCLES+1`.
  - `busy` is high in cycles 1..`ACCESS_CYCLES`.
- `PTS_ser_data_out` lags any change of `index` or `hold_data` by exactly 1 cycle.
- A strobe held low for several cycles counts as a single event. A new capture requires `rd_strb` to deassert for at least 1 cycle first.
- Asserting `FPGA_rst_n` low mid-WAIT aborts immediately to reset values with no capture.

## Configuration
- Macro `PTS_BYTE_MSB_FIRST_EN`.
- Defined: low byte goes first, MSB-first within each byte.
  - `sel = {index[3], ~index[2:0]}`.
  - Index order 0..15 emits bits 7..0, then 15..8.
- Undefined: `sel = index`, i.e. strict LSB-first, bits 0..15.

## Test plan
- Reset: hold `FPGA_rst_n` low with random inputs -> all outputs 0; after release with no strobe, outputs remain 0.
- Single read, ACCESS_CYCLES=4: `PTS_en=1`, strobe low for 1 cycle at cycle 0, `mram_data_in=16'hA5C3` -> `busy` high in cycles 1-4, `hold_data=16'hA5C3` and `data_valid=1` in cycle 5.
- Serial order with `PTS_BYTE_MSB_FIRST_EN` defined, word `16'h00A5`, `index` stepping 0..15 -> `PTS_ser_data_out` is 1,0,1,0,0,1,0,1 then eight 0s, each one cycle after the index change. With the macro undefined -> 1,0,1,0,0,1,0,1,0,...
- Burst: two strobes 20 cycles apart with words `16'h1234` then `16'hBEEF` -> `hold_data` shows `16'h1234`, then `16'hBEEF`; `data_valid` never drops; `overrun=0`.
- Overrun: second strobe 2 cycles after the first -> `overrun=1`, the counter restarts, and only the word present at cycle 2+ACCESS_CYCLES is captured. Dropping `PTS_en` -> `overrun=0` and `data_valid=0` next cycle.
- Reset mid-WAIT: `FPGA_rst_n` pulsed low in cycle 2 of WAIT -> no capture, `hold_data=0`, `busy=0`.
